seg7_monitor: RTL

- Receive side of the 7-segment output bus. Samples a 7-bit active-high segment bus, such as the one driven by the display animation block.
- Filters glitches with a stability window and decodes each new stable pattern to a hex digit.
- Counts frames and measures the clock count between successive frames.
- Used in the bench and in a loopback build to check animation content and speed settings.

---
 rtl/seg7_monitor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg7_monitor.sv
// seg7_monitor: deglitching receiver for a 7-segment bus; commits stable glyphs, decodes them and measures frame spacing.
// Optional: define SEG7_MONITOR_SYNC_EN to add a second capture flop for asynchronous pad sources.
module seg7_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_BIT    = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    output logic                  frame_valid,
    output logic [6:0]            seg_pattern,
    output logic [3:0]            digit,
    output logic                  digit_known,
    output logic [PERIOD_BIT-1:0] frame_period,
    output logic                  period_valid,
    output logic [7:0]            change_count
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {WAIT_FIRST, SETTLING, STABLE} state_t;

    state_t                  state;
    logic [6:0]              s0;
    logic                    s0_valid;
    logic [6:0]              sample;
    logic                    sample_valid;
    logic [6:0]              candidate;
    logic [CW-1:0]           stable_cnt;
    logic                    committed_valid;
    logic [PERIOD_BIT-1:0]   period_cnt;

    // Capture flop carries no reset; its valid flag marks the first post-reset sample.
    always_ff @(posedge clk) begin
        s0 <= seg_in;
        if (reset) s0_valid <= 1'b0;
        else       s0_valid <= 1'b1;
    end

`ifdef SEG7_MONITOR_SYNC_EN
    logic [6:0] s1;
    logic       s1_valid;

    always_ff @(posedge clk) begin
        s1 <= s0;
        if (reset) s1_valid <= 1'b0;
        else       s1_valid <= s0_valid;
    end

    assign sample       = s1;
    assign sample_valid = s1_valid;
`else
    assign sample       = s0;
    assign sample_valid = s0_valid;
`endif

    // Returns {known, digit}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= WAIT_FIRST;
            candidate       <= '0;
            stable_cnt      <= '0;
            committed_valid <= 1'b0;
            period_cnt      <= '0;
            frame_valid     <= 1'b0;
            seg_pattern     <= '0;
            digit           <= '0;
            digit_known     <= 1'b0;
            frame_period    <= '0;
            period_valid    <= 1'b0;
            change_count    <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (period_cnt != '1) period_cnt <= period_cnt + 1'b1;

            if (sample_valid) begin
                if (state == WAIT_FIRST || sample != candidate) begin
                    candidate  <= sample;
                    stable_cnt <= '0;
                    state      <= SETTLING;
                end else if (stable_cnt < CNT_MAX) begin
                    stable_cnt <= stable_cnt + 1'b1;
                end else begin
                    state <= STABLE;
                    // A candidate that merely reverts to the committed glyph is not a new frame.
                    if (candidate != seg_pattern || !committed_valid) begin
                        seg_pattern                <= candidate;
                        {digit_known, digit}       <= decode(candidate);
                        frame_valid                <= 1'b1;
                        change_count               <= change_count + 1'b1;
                        committed_valid            <= 1'b1;
                        period_cnt                 <= PERIOD_BIT'(1);
                        if (committed_valid) begin
                            frame_period <= period_cnt;
                            period_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
